// File: rtl/ps2_cmd_seq_pkg.sv
// Shared constants and types for the PS/2 command sequencer and its helpers.
package ps2_cmd_seq_pkg;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ps2_cmd_seq_if.sv
// Command, receive and ps2_host link signals of the command sequencer.
interface ps2_cmd_seq_if;

   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       cmd_done;
   logic       cmd_fail;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       h_tx_en;
   logic [7:0] h_tx_data;
   logic       h_tx_ack;
   logic       h_tx_err;
   logic       h_rx_en;
   logic [7:0] h_rx_data;
   logic       h_rx_ack;
   logic       h_rx_err;

   // master: the sequencer itself; slave: the consumer plus ps2_host around it.
   modport master (
      input  cmd_valid, cmd_data, h_tx_ack, h_tx_err, h_rx_data, h_rx_ack, h_rx_err,
      output cmd_ready, cmd_done, cmd_fail, rx_valid, rx_byte, h_tx_en, h_tx_data, h_rx_en
   );

   modport slave (
      output cmd_valid, cmd_data, h_tx_ack, h_tx_err, h_rx_data, h_rx_ack, h_rx_err,
      input  cmd_ready, cmd_done, cmd_fail, rx_valid, rx_byte, h_tx_en, h_tx_data, h_rx_en
   );

endinterface

// File: rtl/ps2_ack_timer.sv
// Acknowledge watchdog: counts enabled cycles and flags the last one of CYCLES.
module ps2_ack_timer
   import ps2_cmd_seq_pkg::*;
#(
   parameter int CYCLES = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = cnt_width(CYCLES);

   logic [W-1:0] count;

   assign expired = en && (count == W'(CYCLES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/ps2_cmd_seq.sv
// Sends one command byte to a PS/2 device through ps2_host, retries until 0xFA,
// and forwards every other received byte to the consumer.
module ps2_cmd_seq
   import ps2_cmd_seq_pkg::*;
#(
   parameter int CLK_FREQ       = 100,
   parameter int ACK_TIMEOUT_MS = 20,
   parameter int MAX_RETRY      = 3
) (
   input  logic          clk,
   input  logic          rst,
   ps2_cmd_seq_if.master bus
);

   localparam int TIMEOUT_CYCLES = CLK_FREQ * 1000 * ACK_TIMEOUT_MS;
   localparam int RETRY_W        = cnt_width(MAX_RETRY + 1);

   state_t               state, next_state;
   logic [RETRY_W-1:0]   retry_cnt;
   logic                 tx_en_q;
   logic [7:0]           tx_data_q;
   logic                 accept, attempt_bad, give_up, ack_ok, fwd;
   logic                 timer_clr, timer_en, timer_expired;

   ps2_ack_timer #(.CYCLES(TIMEOUT_CYCLES)) u_ack_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .en      (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      next_state  = state;
      attempt_bad = 1'b0;
      ack_ok      = 1'b0;
      give_up     = 1'b0;
      unique case (state)
         IDLE: if (bus.cmd_valid) next_state = SEND;
         // Ignore link status during the one-cycle gap between attempts.
         SEND: if (tx_en_q) begin
            if (bus.h_tx_err)      attempt_bad = 1'b1;
            else if (bus.h_tx_ack) next_state  = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (bus.h_rx_ack && bus.h_rx_data == PS2_ACK) begin
               ack_ok     = 1'b1;
               next_state = IDLE;
            end else if ((bus.h_rx_ack && bus.h_rx_data == PS2_RESEND) ||
                         bus.h_rx_err || timer_expired) begin
               attempt_bad = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      if (attempt_bad) begin
         give_up    = (retry_cnt == RETRY_W'(MAX_RETRY));
         next_state = give_up ? IDLE : SEND;
      end
   end

   always_comb begin
      accept        = (state == IDLE) && bus.cmd_valid;
      timer_en      = (state == WAIT_ACK);
      timer_clr     = (state != WAIT_ACK);
      fwd           = bus.h_rx_ack &&
                      !((state == WAIT_ACK) &&
                        (bus.h_rx_data == PS2_ACK || bus.h_rx_data == PS2_RESEND));
      bus.cmd_ready = (state == IDLE);
      bus.h_rx_en   = 1'b1;
      bus.h_tx_en   = tx_en_q;
      bus.h_tx_data = tx_data_q;
   end

   // Transmit enable skips one cycle on a SEND-to-SEND retry so ps2_host sees a new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_en_q      <= 1'b0;
         tx_data_q    <= '0;
         retry_cnt    <= '0;
         bus.cmd_done <= 1'b0;
         bus.cmd_fail <= 1'b0;
         bus.rx_valid <= 1'b0;
         bus.rx_byte  <= '0;
      end else begin
         tx_en_q      <= (next_state == SEND) && !((state == SEND) && attempt_bad);
         bus.cmd_done <= ack_ok;
         bus.cmd_fail <= give_up;
         bus.rx_valid <= fwd;
         if (fwd) bus.rx_byte <= bus.h_rx_data;
         if (accept) begin
            tx_data_q <= bus.cmd_data;
            retry_cnt <= '0;
         end else if (attempt_bad && !give_up) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Directed self-checking bench for ps2_cmd_seq with a 10000-cycle acknowledge timeout.
module tb_ps2_cmd_seq;

   localparam int TIMEOUT = 10 * 1000 * 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   tx_starts = 0, done_n = 0, fail_n = 0, rxv_n = 0;
   logic tx_en_prev = 1'b0;

   ps2_cmd_seq_if bus ();

   ps2_cmd_seq #(.CLK_FREQ(10), .ACK_TIMEOUT_MS(1), .MAX_RETRY(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Event counters sampled on the inactive edge.
   always @(negedge clk) begin
      if (bus.h_tx_en && !tx_en_prev) tx_starts <= tx_starts + 1;
      tx_en_prev <= bus.h_tx_en;
      if (bus.cmd_done) done_n <= done_n + 1;
      if (bus.cmd_fail) fail_n <= fail_n + 1;
      if (bus.rx_valid) rxv_n  <= rxv_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [7:0] b);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = b;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic host_done();
      bus.h_tx_ack = 1'b1;
      tick();
      bus.h_tx_ack = 1'b0;
   endtask

   task automatic dev_byte(input logic [7:0] b);
      bus.h_rx_data = b;
      bus.h_rx_ack  = 1'b1;
      tick();
      bus.h_rx_ack  = 1'b0;
   endtask

   initial begin
      int s_tx, s_done, s_fail, s_rxv, n;
      bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00;
      bus.h_tx_ack  = 1'b0; bus.h_tx_err = 1'b0;
      bus.h_rx_data = 8'h00; bus.h_rx_ack = 1'b0; bus.h_rx_err = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_tx_en",     bus.h_tx_en,   0);
      check("rst_tx_data",   bus.h_tx_data, 8'h00);
      check("rst_rx_en",     bus.h_rx_en,   1);
      check("rst_rx_byte",   bus.rx_byte,   8'h00);
      check("rst_pulses",    {bus.cmd_done, bus.cmd_fail, bus.rx_valid}, 3'b000);

      // Normal acknowledge
      s_tx = tx_starts; s_rxv = rxv_n;
      send_cmd(8'hED);
      check("norm_tx_en",     bus.h_tx_en,   1);
      check("norm_cmd_ready", bus.cmd_ready, 0);
      check("norm_tx_data",   bus.h_tx_data, 8'hED);
      host_done();
      check("norm_tx_en_drop", bus.h_tx_en, 0);
      tick(); tick();
      dev_byte(8'hFA);
      check("norm_done",       bus.cmd_done,  1);
      check("norm_ready_back", bus.cmd_ready, 1);
      check("norm_no_rxv",     bus.rx_valid,  0);
      tick();
      check("norm_done_once",  bus.cmd_done,  0);
      check("norm_tx_count",   tx_starts - s_tx, 1);
      check("norm_rxv_count",  rxv_n - s_rxv, 0);

      // Resend then acknowledge
      s_tx = tx_starts; s_fail = fail_n; s_done = done_n;
      send_cmd(8'hED);
      host_done();
      dev_byte(8'hFE);
      check("rsnd_tx_en",   bus.h_tx_en,   1);
      check("rsnd_tx_data", bus.h_tx_data, 8'hED);
      host_done();
      dev_byte(8'hFA);
      check("rsnd_done", bus.cmd_done, 1);
      tick();
      check("rsnd_tx_count",   tx_starts - s_tx, 2);
      check("rsnd_fail_count", fail_n - s_fail, 0);
      check("rsnd_done_count", done_n - s_done, 1);

      // Exhaustion: device keeps asking for resend
      s_tx = tx_starts; s_done = done_n;
      send_cmd(8'h55);
      for (int i = 0; i < 4; i++) begin
         check("exh_tx_en", bus.h_tx_en, 1);
         host_done();
         dev_byte(8'hFE);
         if (i < 3) check("exh_no_fail_yet", bus.cmd_fail, 0);
      end
      check("exh_fail",      bus.cmd_fail,  1);
      check("exh_ready",     bus.cmd_ready, 1);
      check("exh_tx_en_off", bus.h_tx_en,   0);
      tick();
      check("exh_fail_once", bus.cmd_fail, 0);
      check("exh_tx_count",  tx_starts - s_tx, 4);
      check("exh_no_done",   done_n - s_done, 0);

      // Transmit error retry, and error beating ack in the same cycle
      s_tx = tx_starts;
      send_cmd(8'hF4);
      bus.h_tx_err = 1'b1; tick(); bus.h_tx_err = 1'b0;
      check("txerr_gap",   bus.h_tx_en,   0);
      check("txerr_busy",  bus.cmd_ready, 0);
      tick();
      check("txerr_again", bus.h_tx_en,   1);
      bus.h_tx_err = 1'b1; bus.h_tx_ack = 1'b1; tick();
      bus.h_tx_err = 1'b0; bus.h_tx_ack = 1'b0;
      check("txboth_gap",   bus.h_tx_en, 0);
      tick();
      check("txboth_again", bus.h_tx_en, 1);
      host_done();
      dev_byte(8'hFA);
      check("txerr_done",     bus.cmd_done, 1);
      tick();
      check("txerr_tx_count", tx_starts - s_tx, 3);

      // Timeout retransmit latency, receive error retry, ack on the expiry cycle
      s_fail = fail_n;
      send_cmd(8'hF2);
      host_done();
      n = 0;
      while (!bus.h_tx_en && n < TIMEOUT + 20) begin
         tick();
         n++;
      end
      check("tmo_latency", n, TIMEOUT);
      check("tmo_tx_data", bus.h_tx_data, 8'hF2);
      host_done();
      bus.h_rx_err = 1'b1; tick(); bus.h_rx_err = 1'b0;
      check("rxerr_retry", bus.h_tx_en, 1);
      host_done();
      repeat (TIMEOUT - 1) tick();
      dev_byte(8'hFA);
      check("tmo_ack_wins", bus.cmd_done, 1);
      check("tmo_ack_idle", bus.h_tx_en,  0);
      tick();
      check("tmo_no_fail",  fail_n - s_fail, 0);

      // Scan code interleaved with the acknowledge, then bytes in IDLE
      send_cmd(8'hF3);
      host_done();
      dev_byte(8'h1C);
      check("intl_rxv",     bus.rx_valid,  1);
      check("intl_byte",    bus.rx_byte,   8'h1C);
      check("intl_waiting", bus.cmd_ready, 0);
      tick();
      check("intl_rxv_once", bus.rx_valid, 0);
      check("intl_hold",     bus.rx_byte,  8'h1C);
      dev_byte(8'hFA);
      check("intl_done",    bus.cmd_done, 1);
      check("intl_fa_eaten", bus.rx_valid, 0);
      dev_byte(8'h1C);
      check("idle_rxv",  bus.rx_valid, 1);
      check("idle_byte", bus.rx_byte,  8'h1C);
      dev_byte(8'hFE);
      check("idle_fe_fwd",  bus.rx_byte,  8'hFE);
      check("idle_fe_done", bus.cmd_done, 0);
      bus.h_rx_err = 1'b1; tick(); bus.h_rx_err = 1'b0;
      check("idle_rxerr_ignored", bus.cmd_ready, 1);

      // Asynchronous reset while sending
      tick();
      s_done = done_n; s_fail = fail_n;
      send_cmd(8'hAB);
      check("ar_tx_en", bus.h_tx_en, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_tx_en_async", bus.h_tx_en,   0);
      check("ar_ready_async", bus.cmd_ready, 1);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      check("ar_ready_after", bus.cmd_ready, 1);
      check("ar_tx_data",     bus.h_tx_data, 8'h00);
      check("ar_no_pulses",   (done_n - s_done) + (fail_n - s_fail), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
